rom_arbiter: RTL and testbench

Two-port arbiter sharing the single-ported boot ROM between the core's instruction-fetch port (imem) and data port (dmem). Captures single-cycle request pulses from each port, grants the ROM round-robin, and issues one ROM access at a time. Routes each ROM response back to the port that owns it. Write attempts to ROM are terminated locally with an error response and never reach the ROM. Sits between the core's memory ports and `rom`.

---
 rtl/rom_arbiter.sv | 160 ++++++++++++++++
 tb/tb_rom_arbiter.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/rom_arbiter.sv
// rtl/rom_arbiter.sv - round-robin arbiter sharing the boot ROM between imem and dmem
//
// Purpose: captures one-cycle request pulses from the instruction-fetch (imem)
// and data (dmem) ports, grants the ROM round-robin, and issues one ROM access
// at a time. Each ROM response goes back to the port that owns it. Writes never
// reach the ROM; they are answered locally.
//
// Ports:
//   clock     in   system clock, all state on posedge
//   reset     in   asynchronous active-high reset
//   imem_in   in   instruction-fetch request (mem_valid, mem_addr, mem_wstrb)
//   imem_out  out  instruction-fetch response (mem_ready, mem_error, mem_rdata)
//   dmem_in   in   data-port request
//   dmem_out  out  data-port response
//   rom_in    out  request to the ROM (mem_wstrb always 0)
//   rom_out   in   ROM response, mem_ready one cycle after mem_valid

typedef struct packed {
  logic        mem_valid;
  logic [31:0] mem_addr;
  logic [3:0]  mem_wstrb;
} mem_in_type;

typedef struct packed {
  logic        mem_ready;
  logic        mem_error;
  logic [31:0] mem_rdata;
} mem_out_type;

module rom_arbiter #(
  parameter bit WRITE_ERROR = 1'b1
) (
  input  logic        clock,
  input  logic        reset,
  input  mem_in_type  imem_in,
  output mem_out_type imem_out,
  input  mem_in_type  dmem_in,
  output mem_out_type dmem_out,
  output mem_in_type  rom_in,
  input  mem_out_type rom_out
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, WERR} state_t;

  state_t      state, next_state;

  logic        pend_i, pend_d;
  logic [31:0] addr_i, addr_d;
  logic [3:0]  wstrb_i, wstrb_d;

  logic        grant;       // 0 = imem, 1 = dmem
  logic        last_grant;  // port served most recently
  logic        hold;        // turnaround cycle after every response
  logic        rom_valid;
  logic [31:0] rom_addr;

  logic        pick_d;
  logic        do_grant;
  logic [3:0]  win_wstrb;
  logic        done;
  mem_out_type resp;

  // dmem wins when it is the only one pending, or on a tie when imem went last.
  assign pick_d    = pend_d & (~pend_i | ~last_grant);
  assign do_grant  = (state == IDLE) & ~hold & (pend_i | pend_d);
  assign win_wstrb = pick_d ? wstrb_d : wstrb_i;
  assign done      = ((state == WAIT) & rom_out.mem_ready) | (state == WERR);

  // State register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  // Next-state logic
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (do_grant) next_state = (win_wstrb != 4'd0) ? WERR : ISSUE;
      ISSUE:   next_state = WAIT;
      WAIT:    if (rom_out.mem_ready) next_state = IDLE;
      WERR:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Pending slots, grant bookkeeping and the registered ROM request.
  // A new request on a port sets its slot even if that slot is being cleared
  // by a grant in the same cycle, so a back-to-back request is never lost.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pend_i     <= 1'b0;
      pend_d     <= 1'b0;
      addr_i     <= 32'd0;
      addr_d     <= 32'd0;
      wstrb_i    <= 4'd0;
      wstrb_d    <= 4'd0;
      grant      <= 1'b0;
      last_grant <= 1'b1;
      hold       <= 1'b0;
      rom_valid  <= 1'b0;
      rom_addr   <= 32'd0;
    end else begin
      if (imem_in.mem_valid) begin
        pend_i  <= 1'b1;
        addr_i  <= imem_in.mem_addr;
        wstrb_i <= imem_in.mem_wstrb;
      end else if (do_grant & ~pick_d) begin
        pend_i  <= 1'b0;
      end

      if (dmem_in.mem_valid) begin
        pend_d  <= 1'b1;
        addr_d  <= dmem_in.mem_addr;
        wstrb_d <= dmem_in.mem_wstrb;
      end else if (do_grant & pick_d) begin
        pend_d  <= 1'b0;
      end

      if (do_grant) begin
        grant    <= pick_d;
        rom_addr <= pick_d ? addr_d : addr_i;
      end

      // One-cycle pulse in ISSUE, only for reads.
      rom_valid <= do_grant & (win_wstrb == 4'd0);

      if (done) last_grant <= grant;
      hold <= done;
    end
  end

  // Output logic: WAIT forwards the ROM response combinationally; WERR is
  // decoded purely from registered state.
  always_comb begin
    resp             = '0;
    imem_out         = '0;
    dmem_out         = '0;
    rom_in           = '0;
    rom_in.mem_valid = rom_valid;
    rom_in.mem_addr  = rom_addr;
    case (state)
      WAIT: begin
        if (rom_out.mem_ready) begin
          resp.mem_ready = 1'b1;
          resp.mem_error = rom_out.mem_error;
          resp.mem_rdata = rom_out.mem_rdata;
        end
      end
      WERR: begin
        resp.mem_ready = 1'b1;
        resp.mem_error = WRITE_ERROR;
      end
      default: resp = '0;
    endcase
    if (grant) dmem_out = resp;
    else       imem_out = resp;
  end

endmodule

// File: tb/tb_rom_arbiter.sv
// tb/tb_rom_arbiter.sv - directed self-checking bench for rom_arbiter
module tb_rom_arbiter;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  mem_in_type  imem_in, dmem_in;
  mem_out_type imem_out, dmem_out, imem_out0, dmem_out0;
  mem_in_type  rom_in, rom_in0;
  mem_out_type rom_out, rom_out0;

  logic        rom_rdy = 1'b0, rom_rdy0 = 1'b0;
  logic [31:0] rom_dat = 32'd0, rom_dat0 = 32'd0;
  logic        stale = 1'b0;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  rom_arbiter #(.WRITE_ERROR(1'b1)) dut (
    .clock(clock), .reset(reset),
    .imem_in(imem_in), .imem_out(imem_out),
    .dmem_in(dmem_in), .dmem_out(dmem_out),
    .rom_in(rom_in), .rom_out(rom_out)
  );

  rom_arbiter #(.WRITE_ERROR(1'b0)) dut_we0 (
    .clock(clock), .reset(reset),
    .imem_in(imem_in), .imem_out(imem_out0),
    .dmem_in(dmem_in), .dmem_out(dmem_out0),
    .rom_in(rom_in0), .rom_out(rom_out0)
  );

  function automatic logic [31:0] rom_word(input logic [31:0] a);
    case (a)
      32'h00:  rom_word = 32'h41014081;
      32'h40:  rom_word = 32'h60028293;
      32'h44:  rom_word = 32'h3002A073;
      32'h10:  rom_word = 32'h00000013;
      default: rom_word = 32'h0;
    endcase
  endfunction

  // ROM models: ready one cycle after valid; not reset with the arbiter.
  always_ff @(posedge clock) begin
    rom_rdy  <= rom_in.mem_valid;
    rom_dat  <= rom_word(rom_in.mem_addr);
    rom_rdy0 <= rom_in0.mem_valid;
    rom_dat0 <= rom_word(rom_in0.mem_addr);
  end

  assign rom_out.mem_ready  = rom_rdy | stale;
  assign rom_out.mem_error  = 1'b0;
  assign rom_out.mem_rdata  = stale ? 32'hDEADBEEF : rom_dat;
  assign rom_out0.mem_ready = rom_rdy0;
  assign rom_out0.mem_error = 1'b0;
  assign rom_out0.mem_rdata = rom_dat0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    tick();
  endtask

  initial begin
    imem_in = '0;
    dmem_in = '0;

    // Reset state
    tick();
    check("rst_imem_out", {imem_out.mem_ready, imem_out.mem_error, imem_out.mem_rdata[29:0]}, 32'd0);
    check("rst_dmem_out", {dmem_out.mem_ready, dmem_out.mem_error, dmem_out.mem_rdata[29:0]}, 32'd0);
    check("rst_rom_in", {rom_in.mem_valid, rom_in.mem_wstrb, rom_in.mem_addr[26:0]}, 32'd0);
    do_reset();

    // Single imem read of 0x00
    imem_in = '{mem_valid: 1'b1, mem_addr: 32'h00, mem_wstrb: 4'h0};
    tick();  // N+1
    imem_in = '0;
    check("rd_n1_valid", {31'd0, rom_in.mem_valid}, 32'd0);
    tick();  // N+2
    check("rd_n2_valid", {31'd0, rom_in.mem_valid}, 32'd1);
    check("rd_n2_addr", rom_in.mem_addr, 32'h00);
    check("rd_n2_ready", {31'd0, imem_out.mem_ready}, 32'd0);
    tick();  // N+3
    check("rd_n3_ready", {30'd0, imem_out.mem_ready, imem_out.mem_error}, 32'd2);
    check("rd_n3_rdata", imem_out.mem_rdata, 32'h41014081);
    check("rd_n3_dmem", {dmem_out.mem_ready, dmem_out.mem_error, dmem_out.mem_rdata[29:0]}, 32'd0);
    check("rd_n3_rom_wstrb", {28'd0, rom_in.mem_wstrb}, 32'd0);
    tick();  // N+4
    check("rd_n4_ready", {31'd0, imem_out.mem_ready}, 32'd0);

    // Simultaneous requests straight after reset: imem wins the tie
    do_reset();
    imem_in = '{mem_valid: 1'b1, mem_addr: 32'h40, mem_wstrb: 4'h0};
    dmem_in = '{mem_valid: 1'b1, mem_addr: 32'h44, mem_wstrb: 4'h0};
    tick();  // N+1
    imem_in = '0;
    dmem_in = '0;
    tick();  // N+2
    tick();  // N+3
    check("tie_n3_imem_ready", {31'd0, imem_out.mem_ready}, 32'd1);
    check("tie_n3_imem_rdata", imem_out.mem_rdata, 32'h60028293);
    check("tie_n3_dmem_ready", {31'd0, dmem_out.mem_ready}, 32'd0);
    tick();  // N+4
    tick();  // N+5
    tick();  // N+6
    check("tie_n6_rom_valid", {31'd0, rom_in.mem_valid}, 32'd1);
    check("tie_n6_rom_addr", rom_in.mem_addr, 32'h44);
    check("tie_n6_dmem_ready", {31'd0, dmem_out.mem_ready}, 32'd0);
    tick();  // N+7
    check("tie_n7_dmem_ready", {31'd0, dmem_out.mem_ready}, 32'd1);
    check("tie_n7_dmem_rdata", dmem_out.mem_rdata, 32'h3002A073);
    check("tie_n7_imem_ready", {31'd0, imem_out.mem_ready}, 32'd0);
    tick();
    tick();

    // dmem write: local response, never reaches the ROM
    dmem_in = '{mem_valid: 1'b1, mem_addr: 32'h10, mem_wstrb: 4'hF};
    tick();  // N+1
    dmem_in = '0;
    check("wr_n1_rom_valid", {31'd0, rom_in.mem_valid}, 32'd0);
    tick();  // N+2
    check("wr_n2_resp", {30'd0, dmem_out.mem_ready, dmem_out.mem_error}, 32'd3);
    check("wr_n2_rdata", dmem_out.mem_rdata, 32'd0);
    check("wr_n2_rom_valid", {31'd0, rom_in.mem_valid}, 32'd0);
    check("wr_n2_imem", {31'd0, imem_out.mem_ready}, 32'd0);
    check("wr0_n2_resp", {30'd0, dmem_out0.mem_ready, dmem_out0.mem_error}, 32'd2);
    tick();  // N+3
    check("wr_n3_rom_valid", {30'd0, rom_in.mem_valid, rom_in0.mem_valid}, 32'd0);
    check("wr_n3_ready", {31'd0, dmem_out.mem_ready}, 32'd0);
    tick();
    tick();

    // Round-robin: imem re-requests in its ready cycle while dmem is pending
    imem_in = '{mem_valid: 1'b1, mem_addr: 32'h00, mem_wstrb: 4'h0};
    tick();  // N+1
    imem_in = '0;
    dmem_in = '{mem_valid: 1'b1, mem_addr: 32'h44, mem_wstrb: 4'h0};
    tick();  // N+2
    dmem_in = '0;
    tick();  // N+3
    check("rr_n3_imem_rdata", imem_out.mem_rdata, 32'h41014081);
    imem_in = '{mem_valid: 1'b1, mem_addr: 32'h40, mem_wstrb: 4'h0};
    tick();  // N+4
    imem_in = '0;
    tick();  // N+5
    tick();  // N+6
    check("rr_n6_rom_addr", rom_in.mem_addr, 32'h44);
    tick();  // N+7
    check("rr_n7_dmem", {dmem_out.mem_ready, imem_out.mem_ready, dmem_out.mem_rdata[29:0]},
          {2'b10, 30'h3002A073});
    tick();  // N+8
    tick();  // N+9
    tick();  // N+10
    check("rr_n10_rom_addr", rom_in.mem_addr, 32'h40);
    tick();  // N+11
    check("rr_n11_imem_ready", {30'd0, imem_out.mem_ready, dmem_out.mem_ready}, 32'd2);
    check("rr_n11_imem_rdata", imem_out.mem_rdata, 32'h60028293);
    tick();
    tick();

    // Reset mid-WAIT with dmem pending
    do_reset();
    imem_in = '{mem_valid: 1'b1, mem_addr: 32'h00, mem_wstrb: 4'h0};
    tick();  // N+1
    imem_in = '0;
    dmem_in = '{mem_valid: 1'b1, mem_addr: 32'h10, mem_wstrb: 4'h0};
    tick();  // N+2
    dmem_in = '0;
    tick();  // N+3, in WAIT
    check("mr_wait_ready", {31'd0, imem_out.mem_ready}, 32'd1);
    reset = 1'b1;
    #1;
    check("mr_imem_cleared", {imem_out.mem_ready, imem_out.mem_error, imem_out.mem_rdata[29:0]}, 32'd0);
    check("mr_dmem_cleared", {dmem_out.mem_ready, dmem_out.mem_error, dmem_out.mem_rdata[29:0]}, 32'd0);
    check("mr_rom_cleared", {rom_in.mem_valid, rom_in.mem_addr[30:0]}, 32'd0);
    @(posedge clock);
    #1;
    reset = 1'b0;
    stale = 1'b1;
    #1;
    check("mr_stale_ignored", {30'd0, imem_out.mem_ready, dmem_out.mem_ready}, 32'd0);
    tick();
    stale = 1'b0;
    for (int i = 0; i < 6; i++) begin
      check("mr_no_resp", {29'd0, imem_out.mem_ready, dmem_out.mem_ready, rom_in.mem_valid}, 32'd0);
      tick();
    end

    // A fresh request still works after the mid-access reset
    imem_in = '{mem_valid: 1'b1, mem_addr: 32'h44, mem_wstrb: 4'h0};
    tick();
    imem_in = '0;
    tick();
    tick();
    check("mr_new_ready", {30'd0, imem_out.mem_ready, dmem_out.mem_ready}, 32'd2);
    check("mr_new_rdata", imem_out.mem_rdata, 32'h3002A073);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
